// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage stall vector, exception/eret
// freeze-flush-resume sequencing, stall watchdog and flush counter.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE     = 32'h0000_000e,
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [15:0] flush_count
);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  localparam logic [15:0] TO_LAST = STALL_TIMEOUT - 16'd1;

  state_t      state;
  state_t      state_next;
  logic        exc;
  logic [15:0] stall_cnt;

  assign exc = |excepttype_i;

  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 6'b000000;
    unique case (state)
      RUN: begin
        if (exc) begin
          stall      = 6'b111111;
          state_next = FLUSH;
        end else if (stallreq_from_mem) begin
          stall = 6'b011111;
        end else if (stallreq_from_ex) begin
          stall = 6'b001111;
        end else if (stallreq_from_id) begin
          stall = 6'b000111;
        end else if (stallreq_from_if) begin
          stall = 6'b000011;
        end
      end
      FLUSH: state_next = RUN;
      default: state_next = RUN;
    endcase
    if (!rst) stall = 6'b000000;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      flush         <= 1'b0;
      new_pc        <= 32'h0;
      stall_cnt     <= 16'h0;
      stall_timeout <= 1'b0;
      flush_count   <= 16'h0;
    end else if (state == FLUSH) begin
      flush       <= 1'b0;
      flush_count <= flush_count + 16'd1;
      stall_cnt   <= 16'h0;
    end else if (exc) begin
      flush  <= 1'b1;
      new_pc <= (excepttype_i == ERET_CODE) ? cp0_epc_i
                                            : EXC_VECTOR;
    end else if (stall[0]) begin
      if (stall_cnt != 16'hffff) stall_cnt <= stall_cnt + 16'd1;
      if (stall_cnt == TO_LAST) stall_timeout <= 1'b1;
    end else begin
      stall_cnt <= 16'h0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus random
// traffic, checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

  logic        clk = 1'b1;
  logic        rst;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [15:0] flush_count;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .ERET_CODE    (32'h0000_000e),
    .STALL_TIMEOUT(16'd4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (stallreq_from_if),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .stallreq_from_mem(stallreq_from_mem),
    .excepttype_i     (excepttype_i),
    .cp0_epc_i        (cp0_epc_i),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_timeout    (stall_timeout),
    .flush_count      (flush_count)
  );

  typedef struct {
    int          cyc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        to;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];

  // reference model state
  bit          m_flushing;
  logic [31:0] m_pc;
  int          m_run;
  bit          m_to;
  int          m_fc;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  function automatic logic [5:0] model_stall(
    input logic r, input logic [3:0] req, input logic [31:0] ex);
    if (!r || m_flushing) return 6'd0;
    if (ex != 0)          return 6'b111111;
    if (req[3])           return 6'b011111;
    if (req[2])           return 6'b001111;
    if (req[1])           return 6'b000111;
    if (req[0])           return 6'b000011;
    return 6'd0;
  endfunction

  // req = {mem, ex, id, if}
  task automatic drive(input logic r, input logic [3:0] req,
                       input logic [31:0] ex, input logic [31:0] epc);
    exp_t e;
    rst = r;
    {stallreq_from_mem, stallreq_from_ex,
     stallreq_from_id, stallreq_from_if} = req;
    excepttype_i = ex;
    cp0_epc_i    = epc;
    e.cyc   = cyc;
    e.stall = model_stall(r, req, ex);
    e.flush = m_flushing;
    e.pc    = m_pc;
    e.to    = m_to;
    e.fc    = m_fc[15:0];
    q.push_back(e);
    @(posedge clk);
    if (!r) begin
      m_flushing = 0; m_pc = 0; m_run = 0; m_to = 0; m_fc = 0;
    end else if (m_flushing) begin
      m_flushing = 0;
      m_fc       = (m_fc + 1) % 65536;
      m_run      = 0;
    end else if (ex != 0) begin
      m_flushing = 1;
      m_pc       = (ex == 32'he) ? epc : 32'h20;
    end else if (e.stall[0]) begin
      m_run = m_run + 1;
      if (m_run >= 4) m_to = 1;
    end else begin
      m_run = 0;
    end
    cyc++;
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (stall !== e.stall || flush !== e.flush || new_pc !== e.pc ||
          stall_timeout !== e.to || flush_count !== e.fc) begin
        miscompares++;
        $display("FAIL cyc%0d outputs: got stall=%b flush=%b pc=%h to=%b fc=%0d, want stall=%b flush=%b pc=%h to=%b fc=%0d",
                 e.cyc, stall, flush, new_pc, stall_timeout, flush_count,
                 e.stall, e.flush, e.pc, e.to, e.fc);
      end
    end
  end

  initial begin
    rst = 0;
    {stallreq_from_mem, stallreq_from_ex} = 2'b11;
    {stallreq_from_id, stallreq_from_if}  = 2'b11;
    excepttype_i = 0;
    cp0_epc_i    = 0;
    m_flushing = 0; m_pc = 0; m_run = 0; m_to = 0; m_fc = 0;
    @(posedge clk);
    #1;
    // reset with every request high
    for (int i = 0; i < 3; i++) drive(0, 4'hf, 32'h8, 32'h1234);
    // priority walk
    drive(1, 4'b1111, 0, 0);
    drive(1, 4'b0111, 0, 0);
    drive(1, 4'b0011, 0, 0);
    drive(1, 4'b0001, 0, 0);
    drive(1, 4'b0000, 0, 0);
    // exception held two cycles, then idle
    drive(1, 4'b0000, 32'h8, 0);
    drive(1, 4'b0000, 32'h8, 0);
    drive(1, 4'b0000, 0, 0);
    // eret
    drive(1, 4'b0000, 32'he, 32'h0040_0010);
    drive(1, 4'b0000, 0, 0);
    drive(1, 4'b0000, 0, 0);
    // exception beats mem stall
    drive(1, 4'b1000, 32'h1, 32'h5);
    drive(1, 4'b1000, 32'h1, 32'h5);
    drive(1, 4'b0000, 0, 0);
    // back-to-back: N+2 exception starts a new sequence
    drive(1, 4'b0000, 32'h4, 0);
    drive(1, 4'b0000, 32'he, 32'h77);
    drive(1, 4'b0000, 32'he, 32'h0099_0000);
    drive(1, 4'b0000, 0, 0);
    drive(1, 4'b0000, 0, 0);
    // watchdog
    for (int i = 0; i < 6; i++) drive(1, 4'b0100, 0, 0);
    drive(1, 4'b0000, 0, 0);
    drive(1, 4'b0000, 0, 0);
    // reset during flush
    drive(0, 4'b0000, 0, 0);
    drive(1, 4'b0000, 32'h8, 0);
    drive(0, 4'b0000, 0, 0);
    drive(1, 4'b0000, 0, 0);
    drive(1, 4'b0000, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic [3:0]  req;
      logic [31:0] ex;
      r   = ($urandom_range(0, 40) != 0);
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)
        ex = $urandom_range(0, 1) ? 32'he : ($urandom | 32'h1);
      else
        ex = 0;
      drive(r, req, ex, $urandom);
    end
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. Collects stall requests from the IF, ID, EX and MEM stages and produces the per-stage `stall[5:0]` vector used by the PC register and the pipeline registers. Sequences exception and `eret` handling as a freeze/flush/resume procedure. Supplies `flush` and `new_pc` to the PC register, and keeps a stall watchdog and a flush event counter.

## Interface
Parameters:
- `EXC_VECTOR`, `32'h00000020`: exception handler entry address.
- `ERET_CODE`, `32'h0000000e`: `excepttype_i` value that denotes `eret`.
- `STALL_TIMEOUT`, `16'd1024`: consecutive stalled cycles that set `stall_timeout`.

Ports (`stall` bit mapping: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB):
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-low reset (`rst==0` at the clock edge resets).
- `stallreq_from_if` input 1: instruction memory not ready.
- `stallreq_from_id` input 1: ID load-use or operand hazard.
- `stallreq_from_ex` input 1: EX multicycle operation busy.
- `stallreq_from_mem` input 1: data memory not ready.
- `excepttype_i` input 32: exception code from the MEM stage; zero means no exception.
- `cp0_epc_i` input 32: current CP0 EPC, used as the `eret` target.
- `stall` output 6: per-stage hold (combinational from state and inputs).
- `flush` output 1: registered; clears all pipeline registers and loads `new_pc` into the PC.
- `new_pc` output 32: registered; redirect target, valid while `flush=1`.
- `stall_timeout` output 1: sticky watchdog flag.
- `flush_count` output 16: number of flushes taken; wraps modulo 2^16.

## Operation
States: RUN, FLUSH.

RUN:
- If `excepttype_i != 0`:
  - `stall = 6'b111111`, freezing every stage so nothing advances past MEM.
  - Next state is FLUSH.
  - `flush <= 1`.
  - `new_pc <= cp0_epc_i` when `excepttype_i == ERET_CODE`; otherwise `new_pc <= EXC_VECTOR`.
- Else `stall` is set by the highest-priority active request:
  - mem → `6'b011111`
  - ex → `6'b001111`
  - id → `6'b000111`
  - if → `6'b000011`
  - none → `6'b000000`
- An exception takes precedence over all stall requests in the same cycle.

FLUSH (always exactly one cycle):
- `stall = 6'b000000` and `flush = 1`.
- `excepttype_i` and all stall requests are ignored, because the frozen MEM stage may still present the same code.
- Next state is RUN with `flush <= 0`.
- `flush_count <= flush_count + 1`, wrapping from 16'hFFFF to 0.
- `new_pc` holds its value until the next redirect.

Watchdog:
- A 16-bit `stall_cnt` increments in every RUN cycle where `stall[0]==1` and there is no exception.
- `stall_cnt` clears in any cycle where `stall[0]==0` and in FLUSH.
- `stall_cnt` saturates at 16'hFFFF.
- When `stall_cnt == STALL_TIMEOUT - 1` and the stall persists, `stall_timeout <= 1`.
- `stall_timeout` stays set until reset.

Reset (`rst==0`):
- state RUN
- `flush=0`
- `new_pc=32'h0`
- `stall_cnt=0`
- `stall_timeout=0`
- `flush_count=0`
- `stall` is forced to `6'b000000` during the reset cycle.

A reset in the FLUSH state aborts the flush: `flush=0` from the next cycle, and `flush_count` is not incremented.

## Timing
- Exception visible in cycle N, state RUN: `stall=6'b111111` in N; `flush=1` and `new_pc` valid in N+1; `flush=0` in N+2.
- The PC register loads `new_pc` at the end of N+1, and the first handler fetch occurs in N+2.
- Stall requests map to `stall` combinationally, with zero latency.
- Exceptions arriving in back-to-back cycles: the second one is ignored only if it is in FLUSH; an exception in N+2 starts a new sequence.
- `flush_count` updates at the end of the FLUSH cycle.

## Test plan
- **Reset.** Hold `rst=0` for 3 cycles with every request high → `stall=0`, `flush=0`, `new_pc=0`, `flush_count=0`, `stall_timeout=0`.
- **Stall priority.** Assert if, id, ex and mem together, then drop them one at a time from mem downward → `stall` steps `011111`, `001111`, `000111`, `000011`, `000000`, each in the same cycle as the change.
- **Exception redirect.** `excepttype_i=32'h00000008` held for 2 cycles in cycle N → `stall=111111` in N; `flush=1` and `new_pc=32'h00000020` in N+1; `flush=0` in N+2; `flush_count=1`.
- **Eret redirect.** `excepttype_i=32'h0000000e`, `cp0_epc_i=32'h00400010` → `new_pc=32'h00400010` during the single-cycle flush.
- **Exception beats stall.** `stallreq_from_mem=1` with `excepttype_i=1` → `stall=111111` and the flush sequence is taken.
- **Watchdog and reset mid-flush.** Hold `stallreq_from_ex=1` with `STALL_TIMEOUT=4` → `stall_timeout=1` after 4 stalled cycles and still 1 after the request drops. Separately, pull `rst=0` in the FLUSH cycle → `flush=0` the next cycle and `flush_count` unchanged.
